// File: rtl/bram_fifo_if.sv
// bram_fifo_if: FIFO method signals (enq/deq/first/count) plus the BRAM client port.
// master is the FIFO side; slave is the producer/consumer/BRAM-server side.
interface bram_fifo_if #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 4
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 3);

    logic             enq_ena;
    logic [WIDTH-1:0] enq_v;
    logic             enq_rdy;
    logic             deq_ena;
    logic             deq_rdy;
    logic [WIDTH-1:0] first;
    logic             first_rdy;
    logic [CNTW-1:0]  count;
    logic             bram_write_ena;
    logic [AW-1:0]    bram_write_addr;
    logic [WIDTH-1:0] bram_write_data;
    logic             bram_write_rdy;
    logic             bram_read_ena;
    logic [AW-1:0]    bram_read_addr;
    logic             bram_read_rdy;
    logic [WIDTH-1:0] bram_data_out;
    logic             bram_data_out_rdy;

    modport master (
        input  enq_ena, enq_v, deq_ena,
        input  bram_write_rdy, bram_read_rdy, bram_data_out, bram_data_out_rdy,
        output enq_rdy, deq_rdy, first, first_rdy, count,
        output bram_write_ena, bram_write_addr, bram_write_data,
        output bram_read_ena, bram_read_addr
    );

    modport slave (
        output enq_ena, enq_v, deq_ena,
        output bram_write_rdy, bram_read_rdy, bram_data_out, bram_data_out_rdy,
        input  enq_rdy, deq_rdy, first, first_rdy, count,
        input  bram_write_ena, bram_write_addr, bram_write_data,
        input  bram_read_ena, bram_read_addr
    );
endinterface

// File: rtl/bram_fifo.sv
// bram_fifo: FIFO with bulk storage in an external one-cycle-latency BRAM and a
// two-entry prefetching output buffer for one-entry-per-cycle throughput.
module bram_fifo #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 4
) (
    input  logic       CLK,
    input  logic       nRST,
    bram_fifo_if.master io
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int CNTW = $clog2(DEPTH + 3);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    mem_count_q, mem_count_d;
    logic             pending_q, pending_d;
    logic [1:0]       out_count_q, out_count_d;
    logic [WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]       base;
    logic             cap, rd;

    always_comb begin
        cap         = pending_q && io.bram_data_out_rdy;
        out_count_d = out_count_q + 2'(cap) - 2'(io.deq_ena);
        // only prefetch when the returning word is sure to find a free slot
        rd          = (mem_count_q != '0) && io.bram_read_rdy && !out_count_d[1];
        base        = out_count_q - 2'(io.deq_ena);
        wptr_d      = io.enq_ena ? (wptr_q == LAST ? '0 : wptr_q + AW'(1)) : wptr_q;
        rptr_d      = rd ? (rptr_q == LAST ? '0 : rptr_q + AW'(1)) : rptr_q;
        mem_count_d = mem_count_q + CW'(io.enq_ena) - CW'(rd);
        pending_d   = rd;
        buf0_d      = (cap && base == 2'd0) ? io.bram_data_out : (io.deq_ena ? buf1_q : buf0_q);
        buf1_d      = (cap && base == 2'd1) ? io.bram_data_out : buf1_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            mem_count_q <= '0;
            pending_q   <= 1'b0;
            out_count_q <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            mem_count_q <= mem_count_d;
            pending_q   <= pending_d;
            out_count_q <= out_count_d;
        end
    end

    always_ff @(posedge CLK) begin
        buf0_q <= buf0_d;
        buf1_q <= buf1_d;
    end

    assign io.enq_rdy         = (mem_count_q != FULL) && io.bram_write_rdy;
    assign io.first_rdy       = out_count_q != '0;
    assign io.deq_rdy         = io.first_rdy;
    assign io.first           = buf0_q;
    assign io.count           = CNTW'(mem_count_q) + CNTW'(pending_q) + CNTW'(out_count_q);
    assign io.bram_write_ena  = io.enq_ena;
    assign io.bram_write_addr = wptr_q;
    assign io.bram_write_data = io.enq_v;
    assign io.bram_read_ena   = rd;
    assign io.bram_read_addr  = rptr_q;
endmodule

// File: tb/tb_bram_fifo.sv
// tb_bram_fifo: directed test of bram_fifo (depth 6) against a behavioural BRAM
// and a reference queue of expected head values.
module tb_bram_fifo;
    localparam int DEPTH = 6;
    localparam int WIDTH = 4;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    bram_fifo_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) io ();
    bram_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (.CLK(CLK), .nRST(nRST), .io(io));

    logic [WIDTH-1:0] mem [0:7];
    logic [WIDTH-1:0] dout;
    always @(posedge CLK) begin
        if (io.bram_write_ena) mem[io.bram_write_addr] <= io.bram_write_data;
        if (io.bram_read_ena) dout <= mem[io.bram_read_addr];
    end
    assign io.bram_data_out = dout;

    logic [WIDTH-1:0] exp_q [$];
    int n_chk = 0, n_fail = 0, n_enq = 0, n_deq = 0;
    int wexp = 0, rexp = 0;
    logic s_enq_rdy, s_first_rdy, s_read_ena, s_write_ena;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one clock cycle: drive at posedge+1, sample and score at negedge
    task automatic step(input bit want_e, input logic [WIDTH-1:0] v, input bit want_d);
        io.enq_ena = want_e && io.enq_rdy;
        io.enq_v   = v;
        io.deq_ena = want_d && io.first_rdy;
        @(negedge CLK);
        s_enq_rdy   = io.enq_rdy;
        s_first_rdy = io.first_rdy;
        s_read_ena  = io.bram_read_ena;
        s_write_ena = io.bram_write_ena;
        chk("count", io.count, exp_q.size());
        chk("write_ena", io.bram_write_ena, io.enq_ena);
        if (exp_q.size() == 0) chk("first_rdy_empty", io.first_rdy, 0);
        if (io.enq_ena) begin
            chk("write_addr", io.bram_write_addr, wexp);
            chk("write_data", io.bram_write_data, v);
            wexp = (wexp == DEPTH - 1) ? 0 : wexp + 1;
            exp_q.push_back(v);
            n_enq++;
        end
        if (io.bram_read_ena) begin
            chk("read_addr", io.bram_read_addr, rexp);
            rexp = (rexp == DEPTH - 1) ? 0 : rexp + 1;
        end
        if (io.deq_ena && exp_q.size() != 0) begin
            chk("first", io.first, exp_q.pop_front());
            n_deq++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) step(1'b0, '0, 1'b1);
        chk("drain_empty", exp_q.size(), 0);
        step(1'b0, '0, 1'b0);
    endtask

    initial begin
        int d0, e0;
        nRST = 1'b0;
        io.enq_ena = 1'b0;
        io.enq_v = '0;
        io.deq_ena = 1'b0;
        io.bram_write_rdy = 1'b1;
        io.bram_read_rdy = 1'b1;
        io.bram_data_out_rdy = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_first_rdy", io.first_rdy, 0);
        chk("rst_deq_rdy", io.deq_rdy, 0);
        chk("rst_count", io.count, 0);
        chk("rst_read_ena", io.bram_read_ena, 0);
        chk("rst_write_ena", io.bram_write_ena, 0);
        chk("rst_enq_rdy", io.enq_rdy, 1);
        io.bram_write_rdy = 1'b0;
        #1;
        chk("rst_enq_rdy_follow", io.enq_rdy, 0);
        io.bram_write_rdy = 1'b1;
        @(posedge CLK);
        #1;
        nRST = 1'b1;

        // single-entry latency
        step(1'b1, 4'h3, 1'b0);
        chk("lat_write", s_write_ena, 1);
        step(1'b0, '0, 1'b0);
        chk("lat_read", s_read_ena, 1);
        chk("lat_first_n1", s_first_rdy, 0);
        step(1'b0, '0, 1'b0);
        chk("lat_first_n2", s_first_rdy, 0);
        step(1'b0, '0, 1'b1);
        chk("lat_first_n3", s_first_rdy, 1);
        step(1'b0, '0, 1'b0);

        // back-to-back stream
        d0 = n_deq;
        for (int i = 0; i < 20; i++) step(1'b1, 4'(i), 1'b1);
        chk("stream_deqs", n_deq - d0, 17);
        drain();

        // fill to capacity (DEPTH + 2)
        e0 = n_enq;
        for (int i = 0; i < 12; i++) step(1'b1, 4'(i + 5), 1'b0);
        chk("fill_accepted", n_enq - e0, DEPTH + 2);
        chk("fill_count", io.count, DEPTH + 2);
        chk("fill_enq_rdy", io.enq_rdy, 0);
        step(1'b0, '0, 1'b1);
        chk("fill_deq_cycle_rdy", s_enq_rdy, 0);
        chk("fill_after_deq_rdy", io.enq_rdy, 1);
        drain();

        // pointer wrap with random gaps
        e0 = n_enq;
        for (int k = 0; k < 600 && !((n_enq - e0) >= 40 && exp_q.size() == 0); k++)
            step((n_enq - e0) < 40 && $urandom_range(0, 2) != 0, 4'($urandom), $urandom_range(0, 2) != 0);
        chk("wrap_enqs", n_enq - e0, 40);
        chk("wrap_empty", exp_q.size(), 0);

        // read stall
        io.bram_read_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(i < 3, 4'(9 + i), 1'b1);
            chk("hold_read", s_read_ena, 0);
            chk("hold_first_rdy", s_first_rdy, 0);
        end
        io.bram_read_rdy = 1'b1;
        drain();

        // reset while a read is in flight
        step(1'b1, 4'h5, 1'b0);
        step(1'b1, 4'h6, 1'b0);
        chk("pre_rst_read", s_read_ena, 1);
        nRST = 1'b0;
        #1;
        chk("mid_rst_first_rdy", io.first_rdy, 0);
        chk("mid_rst_count", io.count, 0);
        chk("mid_rst_read_ena", io.bram_read_ena, 0);
        exp_q.delete();
        wexp = 0;
        rexp = 0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        step(1'b1, 4'hA, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        chk("post_rst_first_rdy", io.first_rdy, 1);
        chk("post_rst_first", io.first, 4'hA);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
